// File: rtl/aes_pkg.sv
// Shared AES definitions: state sizes, FSM encoding, GF(2^8) doubling and
// column access helpers for the MixColumns datapath.
package aes_pkg;

  localparam int AES_DATA_LEN = 128;
  localparam int AES_NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Column c occupies [127-32c -: 32], row 0 in the most significant byte.
  function automatic logic [31:0] get_col(input logic [AES_DATA_LEN-1:0] s,
                                          input logic [1:0] c);
    return s[AES_DATA_LEN-1-32*int'(c) -: 32];
  endfunction

  function automatic logic [AES_DATA_LEN-1:0] set_col(input logic [AES_DATA_LEN-1:0] s,
                                                      input logic [1:0] c,
                                                      input logic [31:0] v);
    logic [AES_DATA_LEN-1:0] r;
    r = s;
    r[AES_DATA_LEN-1-32*int'(c) -: 32] = v;
    return r;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns of one 32-bit column (a0 in the MSB byte).
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] d0, d1, d2, d3;

  assign {a0, a1, a2, a3} = col_i;

  assign d0 = xtime(a0);
  assign d1 = xtime(a1);
  assign d2 = xtime(a2);
  assign d3 = xtime(a3);

  // 3*x is expressed as 2*x ^ x.
  assign col_o[31:24] = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
  assign col_o[7:0]   = (d0 ^ a0) ^ a1 ^ a2 ^ d3;

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: one column per clock through a single
// column multiplier, with valid/ready on both sides and a last-round bypass.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int DATA_LEN = AES_DATA_LEN,
  parameter int NUM_COLS = AES_NUM_COLS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                last_round,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [DATA_LEN-1:0] data_out
);

  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  state_t              state_q;
  logic [1:0]          col_cnt_q;
  logic [DATA_LEN-1:0] work_q;
  logic [DATA_LEN-1:0] data_out_q;
  logic                valid_out_q;

  logic                accept;
  logic [31:0]         col_in;
  logic [31:0]         col_mixed;
  logic [DATA_LEN-1:0] work_mixed;

  assign col_in     = get_col(work_q, col_cnt_q);
  assign work_mixed = set_col(work_q, col_cnt_q, col_mixed);

  mix_single_column u_mix (
    .col_i (col_in),
    .col_o (col_mixed)
  );

  // Gated by reset so upstream never sees ready while the block is held.
  assign ready_in = reset & ((state_q == IDLE) | ((state_q == DONE) & ready_out));
  assign accept   = valid_in & ready_in;

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      work_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else if (accept) begin
      // Covers both IDLE and the DONE handshake-with-accept case.
      work_q    <= data_in;
      col_cnt_q <= '0;
      if (last_round) begin
        data_out_q  <= data_in;
        valid_out_q <= 1'b1;
        state_q     <= DONE;
      end else begin
        valid_out_q <= 1'b0;
        state_q     <= BUSY;
      end
    end else begin
      unique case (state_q)
        BUSY: begin
          work_q <= work_mixed;
          if (col_cnt_q == LAST_COL) begin
            data_out_q  <= work_mixed;
            valid_out_q <= 1'b1;
            col_cnt_q   <= '0;
            state_q     <= DONE;
          end else begin
            col_cnt_q <= col_cnt_q + 2'd1;
          end
        end
        DONE: begin
          if (ready_out) begin
            valid_out_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter against a generic GF(2^8) matrix model.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         ready_in;
  logic [127:0] data_in;
  logic         last_round;
  logic         valid_out;
  logic         ready_out;
  logic [127:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mix_columns_iter dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .data_in    (data_in),
    .last_round (last_round),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .data_out   (data_out)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Peasant multiplication modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s);
    logic [7:0]   base [4] = '{8'd2, 8'd3, 8'd1, 8'd1};
    logic [7:0]   b [16];
    logic [127:0] r;
    logic [7:0]   acc;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(base[(k - row + 4) % 4], b[4*c+k]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!ready_in && w < 50) begin @(negedge clk); w++; end
    chk({tag, "_rdy"}, 128'(ready_in), 128'd1);
  endtask

  // Measures edges from the accept edge (inclusive) to valid_out.
  task automatic wait_valid(output int lat, output bit rdy_seen);
    lat = 1; rdy_seen = 0;
    while (!valid_out && lat < 20) begin
      if (ready_in) rdy_seen = 1;
      @(negedge clk); lat++;
    end
  endtask

  task automatic send(input logic [127:0] d, input logic lr, input string tag);
    int lat; bit rs;
    logic [127:0] exp;
    exp = lr ? d : mix_ref(d);
    @(negedge clk);
    valid_in = 1'b1; data_in = d; last_round = lr;
    wait_ready(tag);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0; data_in = rnd128(); last_round = 1'($urandom);
    wait_valid(lat, rs);
    chk({tag, "_lat"}, 128'(lat), lr ? 128'd1 : 128'd5);
    chk({tag, "_busy_rdy"}, 128'(rs), 128'd0);
    chk({tag, "_data"}, data_out, exp);
  endtask

  initial begin
    logic [127:0] q [4];
    logic [127:0] fips_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    logic [127:0] fips_out = 128'h046681e5e0cb199a48f8d37a2806264c;
    logic [127:0] nxt      = 128'h0123456789abcdeffedcba9876543210;
    logic [127:0] first_d;
    int lat, cnt; bit rs;

    reset = 1'b0; valid_in = 1'b0; data_in = '0; last_round = 1'b0; ready_out = 1'b1;
    #12;
    chk("rst_valid", 128'(valid_out), 128'd0);
    chk("rst_data", data_out, 128'd0);
    chk("rst_ready", 128'(ready_in), 128'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 128'(ready_in), 128'd1);

    chk("model_fips", mix_ref(fips_in), fips_out);
    send(fips_in, 1'b0, "fips");
    send(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, "colvec");
    chk("colvec_const", data_out, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
    send(128'h00112233445566778899aabbccddeeff, 1'b1, "bypass");

    for (int i = 0; i < 10; i++) send(rnd128(), 1'($urandom_range(0, 1)), "rand");

    // Back-to-back bypass: one result per cycle.
    for (int i = 0; i < 4; i++) q[i] = rnd128();
    @(negedge clk);
    valid_in = 1'b1; data_in = q[0]; last_round = 1'b1;
    wait_ready("b2b");
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_valid", 128'(valid_out), 128'd1);
      chk("b2b_data", data_out, q[i-1]);
      if (i < 4) begin
        chk("b2b_ready", 128'(ready_in), 128'd1);
        data_in = q[i];
      end else valid_in = 1'b0;
    end

    // Back-pressure, then release with a simultaneous new accept.
    @(negedge clk);
    ready_out = 1'b0;
    valid_in = 1'b1; data_in = fips_in; last_round = 1'b0;
    wait_ready("bp");
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    wait_valid(lat, rs);
    chk("bp_lat", 128'(lat), 128'd5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(valid_out), 128'd1);
      chk("bp_hold_data", data_out, fips_out);
      chk("bp_hold_ready", 128'(ready_in), 128'd0);
    end
    ready_out = 1'b1; valid_in = 1'b1; data_in = nxt; last_round = 1'b0;
    #1;
    chk("bp_release_ready", 128'(ready_in), 128'd1);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    chk("bp_valid_drop", 128'(valid_out), 128'd0);
    wait_valid(lat, rs);
    chk("bp_second_lat", 128'(lat), 128'd5);
    chk("bp_second_data", data_out, mix_ref(nxt));

    // valid_in pulsed during BUSY must be ignored.
    first_d = rnd128();
    @(negedge clk);
    valid_in = 1'b1; data_in = first_d; last_round = 1'b0;
    wait_ready("filt");
    @(posedge clk);
    @(negedge clk);
    data_in = rnd128(); last_round = 1'b1;
    @(negedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_out) begin
        cnt++;
        chk("filt_data", data_out, mix_ref(first_d));
      end
      @(negedge clk);
    end
    chk("filt_count", 128'(cnt), 128'd1);

    // Reset in the middle of BUSY.
    @(negedge clk);
    valid_in = 1'b1; data_in = rnd128(); last_round = 1'b0;
    wait_ready("midrst");
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 128'(valid_out), 128'd0);
    chk("midrst_data", data_out, 128'd0);
    chk("midrst_ready", 128'(ready_in), 128'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_rel_ready", 128'(ready_in), 128'd1);
    send(rnd128(), 1'b0, "after_rst");
    send(rnd128(), 1'b1, "after_rst_byp");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
